// File: rtl/jump_input.sv
// jump_input: turns a bouncy jump pushbutton into a debounced level and a
// charge-based jump request that lasts one game step.
// The raw button passes through a two-flop synchronizer and a debounce
// counter to give btn_level. While the button is held, charge counts game
// steps. Releasing the button arms a jump with that strength, and the jump
// fires on the next game step.
module jump_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int MAX_CHARGE      = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sim_tick,
  input  logic       btn_raw,
  output logic       jump_r,
  output logic [3:0] jump_power,
  output logic       btn_level,
  output logic       charging
);

  // Last count value of a run of mismatches; the level is accepted at this count.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_ONE     = CNT_W'(1);
  localparam logic [3:0]       CHARGE_MAX = 4'(MAX_CHARGE);

  typedef enum logic [1:0] {
    IDLE,
    CHARGING,
    PENDING,
    FIRE
  } jumpState_t;

  // Adds one step of charge, but never goes past the configured maximum.
  function automatic logic [3:0] satInc(input logic [3:0] value);
    return (value >= CHARGE_MAX) ? value : value + 4'd1;
  endfunction

  // A release always gives at least the weakest jump, even with no charge.
  function automatic logic [3:0] floorOne(input logic [3:0] value);
    return (value == 4'd0) ? 4'd1 : value;
  endfunction

  logic             syncP0;
  logic             syncP1;
  logic [CNT_W-1:0] dbCount;
  logic             levelPrev;
  logic             pressEvt;
  logic             releaseEvt;
  jumpState_t       state;
  logic [3:0]       charge;
  logic [3:0]       chargeNext;

  // Two-flop synchronizer; this is the only logic that samples btn_raw.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      syncP0 <= 1'b0;
      syncP1 <= 1'b0;
    end else begin
      syncP0 <= btn_raw;
      syncP1 <= syncP0;
    end
  end

  // Debounce: accept a new level only after it persists for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dbCount   <= '0;
      btn_level <= 1'b0;
    end else if (syncP1 == btn_level) begin
      dbCount <= '0;
    end else if (dbCount == DB_LAST) begin
      dbCount   <= '0;
      btn_level <= syncP1;
    end else begin
      dbCount <= dbCount + DB_ONE;
    end
  end

  // Delayed copy of the accepted level, used to detect press and release edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      levelPrev <= 1'b0;
    end else begin
      levelPrev <= btn_level;
    end
  end

  assign pressEvt   = btn_level & ~levelPrev;
  assign releaseEvt = ~btn_level & levelPrev;

  // Charge after this cycle's game step, so a release in the same cycle still counts it.
  assign chargeNext = sim_tick ? satInc(charge) : charge;

  // Jump FSM: charge while held, latch power on release, fire for one game step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      charge     <= 4'd0;
      jump_r     <= 1'b0;
      jump_power <= 4'd0;
      charging   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pressEvt) begin
            state    <= CHARGING;
            charge   <= 4'd0;
            charging <= 1'b1;
          end
        end
        CHARGING: begin
          charge <= chargeNext;
          if (releaseEvt) begin
            state      <= PENDING;
            jump_power <= floorOne(chargeNext);
            charging   <= 1'b0;
          end
        end
        PENDING: begin
          // Button edges are ignored here; only the game step moves us on.
          if (sim_tick) begin
            state  <= FIRE;
            jump_r <= 1'b1;
          end
        end
        FIRE: begin
          // Hold the request for one whole game step. When it ends, use the
          // current button level to choose the next state.
          if (sim_tick) begin
            jump_r <= 1'b0;
            if (btn_level) begin
              state    <= CHARGING;
              charge   <= 4'd0;
              charging <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_input.sv
// tb_jump_input: directed scenarios plus random button and reset activity.
// Every cycle is compared against a reference model built from the behaviour
// rules: the raw level is seen two edges late, a level is accepted after a
// full window of differing samples, and the jump FSM runs on top of that.
module tb_jump_input;

  localparam int DB    = 4;
  localparam int MAXC  = 15;
  localparam int TICKP = 10;
  localparam int NMAX  = 20000;

  localparam int M_IDLE = 0;
  localparam int M_CHG  = 1;
  localparam int M_PEND = 2;
  localparam int M_FIRE = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sim_tick;
  logic       btn_raw;
  logic       jump_r;
  logic [3:0] jump_power;
  logic       btn_level;
  logic       charging;

  jump_input #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3),
    .MAX_CHARGE(MAXC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sim_tick(sim_tick),
    .btn_raw(btn_raw),
    .jump_r(jump_r),
    .jump_power(jump_power),
    .btn_level(btn_level),
    .charging(charging)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference-model history, indexed by rising-edge number.
  bit   rawAt    [NMAX];
  bit   rstAt    [NMAX];
  bit   levAfter [NMAX];
  int   n        = 3;
  int   lastRst  = 2;
  int   mode     = M_IDLE;
  int   mCharge  = 0;
  int   mPower   = 0;
  logic [6:0] expOut;

  // Observations used by the directed scenarios.
  int   stepsSince;
  int   firstLevelStep;
  bit   levelSeen;
  int   pulses;
  int   highCnt;
  int   powerAtRise;
  bit   jrPrev = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n - 1);
    end
  endtask

  // Level the debounce logic sees just before edge k: raw from two edges earlier.
  // It reads 0 if either synchronizer flop was cleared by reset in between.
  function automatic bit syncSeen(input int k);
    return (!rstAt[k-1] && !rstAt[k-2]) ? rawAt[k-2] : 1'b0;
  endfunction

  task automatic modelEdge(input bit raw, input bit rn, input bit tk);
    bit pressE;
    bit relE;
    bit allDiff;
    int c;
    if (n >= NMAX) begin
      $display("FAIL model_range: got edge %0d, expected below %0d", n, NMAX);
      $fatal(1, "model history exhausted");
    end
    rawAt[n] = raw;
    rstAt[n] = !rn;
    if (!rn) begin
      lastRst     = n;
      levAfter[n] = 1'b0;
      mode        = M_IDLE;
      mCharge     = 0;
      mPower      = 0;
    end else begin
      pressE = (n - 2 >= lastRst) && levAfter[n-1] && !levAfter[n-2];
      relE   = (n - 2 >= lastRst) && !levAfter[n-1] && levAfter[n-2];
      levAfter[n] = levAfter[n-1];
      if (n - DB + 1 > lastRst) begin
        allDiff = 1'b1;
        for (int k = n - DB + 1; k <= n; k++)
          if (syncSeen(k) == levAfter[n-1]) allDiff = 1'b0;
        if (allDiff) levAfter[n] = !levAfter[n-1];
      end
      case (mode)
        M_IDLE: if (pressE) begin mode = M_CHG; mCharge = 0; end
        M_CHG: begin
          c = (tk && mCharge < MAXC) ? mCharge + 1 : mCharge;
          mCharge = c;
          if (relE) begin
            mPower = (c < 1) ? 1 : c;
            mode   = M_PEND;
          end
        end
        M_PEND: if (tk) mode = M_FIRE;
        default: if (tk) begin
          if (levAfter[n-1]) begin mode = M_CHG; mCharge = 0; end
          else mode = M_IDLE;
        end
      endcase
    end
    expOut = {(mode == M_FIRE), 4'(mPower), levAfter[n], (mode == M_CHG)};
    n++;
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare at the falling edge.
  task automatic step(input bit raw, input bit rn);
    bit tk;
    tk = (n % TICKP == 0);
    btn_raw  = raw;
    reset_n  = rn;
    sim_tick = tk;
    modelEdge(raw, rn, tk);
    @(negedge clk);
    checkVal("outs", {jump_r, jump_power, btn_level, charging}, expOut);
    stepsSince++;
    if (btn_level && firstLevelStep == 0) firstLevelStep = stepsSince;
    if (btn_level) levelSeen = 1'b1;
    if (jump_r && !jrPrev) begin
      pulses++;
      powerAtRise = jump_power;
    end
    if (jump_r) highCnt++;
    jrPrev = jump_r;
  endtask

  task automatic clearObs();
    stepsSince     = 0;
    firstLevelStep = 0;
    levelSeen      = 1'b0;
    pulses         = 0;
    highCnt        = 0;
    powerAtRise    = 0;
  endtask

  task automatic waitFire(input string tag);
    int w;
    w = 0;
    while (!jrPrev && w < 40) begin
      step(1'b0, 1'b1);
      w++;
    end
    checkVal(tag, jrPrev, 1);
  endtask

  initial begin
    rstAt[0] = 1'b1;
    rstAt[1] = 1'b1;
    rstAt[2] = 1'b1;
    btn_raw  = 1'b0;
    reset_n  = 1'b0;
    sim_tick = 1'b0;
    clearObs();
    @(negedge clk);

    repeat (3) step(1'b0, 1'b0);
    checkVal("reset_outs", {jump_r, jump_power, btn_level, charging}, 7'h00);
    repeat (5) step(1'b0, 1'b1);

    // Clean press held for 30 cycles, which always covers exactly three game steps.
    clearObs();
    repeat (30) step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
    checkVal("press_latency", firstLevelStep, 6);
    checkVal("power_3ticks", powerAtRise, 3);
    checkVal("pulse_len", highCnt, 10);
    checkVal("pulse_count", pulses, 1);

    // Short glitches never reach the debounced level.
    clearObs();
    repeat (5) begin
      repeat (3) step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b1);
    end
    repeat (20) step(1'b0, 1'b1);
    checkVal("glitch_level", levelSeen, 0);
    checkVal("glitch_pulses", pulses, 0);

    // Long hold saturates the charge.
    clearObs();
    repeat (400) step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
    checkVal("power_sat", powerAtRise, 15);

    // Hold shorter than one game step still gives the minimum power.
    clearObs();
    repeat (5) step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
    checkVal("power_min", powerAtRise, 1);

    // The release lands on a game step that follows two earlier steps.
    while (n % TICKP != 9) step(1'b0, 1'b1);
    clearObs();
    repeat (25) step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
    checkVal("power_coincident", powerAtRise, 3);

    // Press again during FIRE: one pulse, then charging starts over.
    clearObs();
    repeat (30) step(1'b1, 1'b1);
    waitFire("fire_wait_a");
    repeat (40) step(1'b1, 1'b1);
    checkVal("refire_pulses", pulses, 1);
    checkVal("refire_len", highCnt, 10);
    checkVal("refire_charging", charging, 1);
    repeat (60) step(1'b0, 1'b1);

    // A one-cycle reset while jump_r is high aborts the pulse.
    repeat (30) step(1'b1, 1'b1);
    waitFire("fire_wait_b");
    step(1'b0, 1'b0);
    checkVal("reset_in_fire", {jump_r, jump_power, btn_level, charging}, 7'h00);
    clearObs();
    repeat (40) step(1'b0, 1'b1);
    checkVal("no_resume", pulses, 0);

    // A button held through reset is accepted again as a fresh press.
    repeat (20) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    clearObs();
    repeat (10) step(1'b1, 1'b1);
    checkVal("reaccept_latency", firstLevelStep, 6);
    repeat (60) step(1'b0, 1'b1);

    // Random button activity with occasional resets.
    repeat (80) begin
      int  len;
      bit  raw;
      bit  doRst;
      len   = $urandom_range(1, 40);
      raw   = 1'($urandom_range(0, 1));
      doRst = ($urandom_range(0, 30) == 0);
      step(raw, !doRst);
      repeat (len - 1) step(raw, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
